// File: rtl/full_adder.sv
// Registered ripple-carry adder: per-bit full-adder cells chained within a segment,
// with segments separated by pipeline registers that also carry the unconsumed operand bits.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module full_adder #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);
  localparam int P   = PIPE_STAGES;
  localparam int SEG = (WIDTH + P - 1) / P;

  if (P < 1 || P > WIDTH) begin : g_bad_cfg
    $error("full_adder: PIPE_STAGES must lie in 1..WIDTH");
  end

  // *_st[k] is what stage k works on; *_r[k] is what stage k registers.
  logic [P-1:0][WIDTH-1:0] a_st, b_st, s_st, nxt_s;
  logic [P-1:0][WIDTH-1:0] a_r, b_r, s_r;
  logic [P-1:0]            c_st, nxt_c, c_r, vld_pipe;
  logic [WIDTH-1:0]        cell_s;

  assign a_st[0] = a;
  assign b_st[0] = b;
  assign s_st[0] = '0;
  assign c_st[0] = cin;

  for (genvar k = 1; k < P; k++) begin : g_link
    assign a_st[k] = a_r[k-1];
    assign b_st[k] = b_r[k-1];
    assign s_st[k] = s_r[k-1];
    assign c_st[k] = c_r[k-1];
  end

  // Carry enters each segment from the previous stage register, then ripples.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int ST = i / SEG;
    logic ci, s, co;
    if (i % SEG == 0) begin : g_seg_head
      assign ci = c_st[ST];
    end else begin : g_seg_body
      assign ci = g_bit[i-1].co;
    end
    fa_cell u_cell (.a(a_st[ST][i]), .b(b_st[ST][i]), .ci(ci), .s(s), .co(co));
    assign cell_s[i] = s;
  end

  for (genvar k = 0; k < P; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = ((LO + SEG < WIDTH) ? LO + SEG : WIDTH) - 1;
    // Trailing stages can be empty when WIDTH doesn't split evenly; they just pass the carry.
    if (LO < WIDTH) begin : g_carry
      assign nxt_c[k] = g_bit[HI].co;
    end else begin : g_pass
      assign nxt_c[k] = c_st[k];
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_sbit
      if (i >= LO && i <= HI) begin : g_new
        assign nxt_s[k][i] = cell_s[i];
      end else begin : g_old
        assign nxt_s[k][i] = s_st[k][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      s_r      <= '0;
      c_r      <= '0;
      vld_pipe <= '0;
    end else begin
      a_r         <= a_st;
      b_r         <= b_st;
      s_r         <= nxt_s;
      c_r         <= nxt_c;
      vld_pipe[0] <= 1'b1;
      for (int k = 1; k < P; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign sum       = s_r[P-1];
  assign carry     = c_r[P-1];
  assign out_valid = vld_pipe[P-1];

  // Already-consumed operand bits and stale sum bits are dead; synthesis trims them.
  logic unused_ok;
  assign unused_ok = ^{a_r, b_r, a_st, b_st, s_st};
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: four configurations sharing clock and reset, checked
// against plain integer addition with a latency queue.

module tb_full_adder;
  logic clk = 1'b0;
  logic rst_n;

  logic [0:0]  a1, b1, s1;
  logic        c1_in, c1, v1;
  logic [7:0]  a8, b8, s8;
  logic        c8_in, c8, v8;
  logic [7:0]  a84, b84, s84;
  logic        c84_in, c84, v84;
  logic [15:0] a16, b16, s16;
  logic        c16_in, c16, v16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1), .PIPE_STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1_in),
    .sum(s1), .carry(c1), .out_valid(v1));
  full_adder #(.WIDTH(8), .PIPE_STAGES(1)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8_in),
    .sum(s8), .carry(c8), .out_valid(v8));
  full_adder #(.WIDTH(8), .PIPE_STAGES(4)) u84 (
    .clk(clk), .rst_n(rst_n), .a(a84), .b(b84), .cin(c84_in),
    .sum(s84), .carry(c84), .out_valid(v84));
  full_adder #(.WIDTH(16), .PIPE_STAGES(3)) u16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(c16_in),
    .sum(s16), .carry(c16), .out_valid(v16));

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic c);
    return x + y + {31'b0, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic        vc [3];
    logic [16:0] expq [$];
    logic [16:0] e;

    // Reset held with all-ones operands: outputs must be zero before any edge.
    rst_n = 1'b0;
    a1 = 1'b1;   b1 = 1'b1;   c1_in = 1'b1;
    a8 = 8'hFF;  b8 = 8'hFF;  c8_in = 1'b1;
    a84 = 8'hFF; b84 = 8'hFF; c84_in = 1'b1;
    a16 = '1;    b16 = '1;    c16_in = 1'b1;
    #2;
    chk("rst_u1_out",  32'({c1, s1}), 32'd0);
    chk("rst_u1_vld",  32'(v1), 32'd0);
    chk("rst_u8_out",  32'({c8, s8}), 32'd0);
    chk("rst_u84_out", 32'({c84, s84}), 32'd0);
    chk("rst_u84_vld", 32'(v84), 32'd0);
    chk("rst_u16_out", 32'({c16, s16}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_u1",  32'({v1, c1, s1}), 32'd0);
    chk("rst_hold_u16", 32'({v16, c16, s16}), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // 1-bit truth table, abc = 000..111
    for (int v = 0; v < 8; v++) begin
      {a1, b1, c1_in} = 3'(v);
      @(posedge clk);
      #1;
      chk("tt_out", 32'({c1, s1}), ref_add(32'(a1), 32'(b1), c1_in));
      chk("tt_vld", 32'(v1), 32'd1);
    end

    // 8-bit single-stage wrap-around
    a8 = 8'hFF; b8 = 8'h01; c8_in = 1'b0;
    @(posedge clk);
    #1;
    chk("w8_ff_01", 32'({c8, s8}), 32'h100);
    a8 = 8'h7F; b8 = 8'h80; c8_in = 1'b1;
    @(posedge clk);
    #1;
    chk("w8_7f_80", 32'({c8, s8}), ref_add(32'(a8), 32'(b8), c8_in));
    chk("w8_vld", 32'(v8), 32'd1);

    // 8-bit, 4 stages: back-to-back vectors, outputs 4 edges after each is applied
    va = '{8'd3, 8'd200, 8'd255};
    vb = '{8'd4, 8'd100, 8'd255};
    vc = '{1'b0, 1'b1, 1'b1};
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 3) begin
        a84 = va[cyc]; b84 = vb[cyc]; c84_in = vc[cyc];
      end else begin
        a84 = '0; b84 = '0; c84_in = 1'b0;
      end
      @(posedge clk);
      #1;
      if (cyc >= 3) begin
        chk("p4_out", 32'({c84, s84}), ref_add(32'(va[cyc-3]), 32'(vb[cyc-3]), vc[cyc-3]));
        chk("p4_vld", 32'(v84), 32'd1);
      end
    end

    // Reset with two results in flight
    a84 = 8'd50; b84 = 8'd60; c84_in = 1'b0;
    @(posedge clk);
    a84 = 8'd99; b84 = 8'd1;  c84_in = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'({c84, s84}), 32'd0);
    chk("mid_rst_vld", 32'(v84), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    va = '{8'd10, 8'd255, 8'd0};
    vb = '{8'd20, 8'd1,   8'd0};
    vc = '{1'b1, 1'b0, 1'b0};
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 3) begin
        a84 = va[cyc]; b84 = vb[cyc]; c84_in = vc[cyc];
      end
      @(posedge clk);
      #1;
      if (cyc < 3) begin
        chk("refill_vld_lo", 32'(v84), 32'd0);
      end else begin
        chk("refill_vld_hi", 32'(v84), 32'd1);
        chk("refill_out", 32'({c84, s84}), ref_add(32'(va[cyc-3]), 32'(vb[cyc-3]), vc[cyc-3]));
      end
    end

    // 16-bit, 3 stages, random stream against a latency queue
    for (int n = 0; n < 1002; n++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16_in = 1'($urandom);
      @(posedge clk);
      #1;
      expq.push_back(17'(ref_add(32'(a16), 32'(b16), c16_in)));
      if (expq.size() == 3) begin
        e = expq.pop_front();
        chk("rnd16_out", 32'({c16, s16}), 32'(e));
        chk("rnd16_vld", 32'(v16), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
